// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Round-robin arbiter sharing the single push port of a byte FIFO between
// N_REQ producers. Once a producer wins, it keeps the port for up to BURST_LEN
// consecutive words (burst lock). Priority then rotates to the next index.
// Words are accepted with zero latency: gnt, fifo_push and fifo_push_data are
// combinational from the current state and inputs.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous, active-high reset
//   req[N_REQ]      per-requester "word available" (held with data until gnt)
//   req_data        packed words, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   gnt[N_REQ]      one-hot, requester i's word is pushed this cycle
//   fifo_push       push strobe to the FIFO
//   fifo_push_data  word presented to the FIFO (slice of owner, always)
//   fifo_full       FIFO full flag
//   owner           index of the locked or currently selected requester
//   busy            high while a burst lock is held
//   stall_cnt[16]   (ARB_STALL_CNT_EN only) saturating count of cycles with a
//                   pending request blocked by fifo_full
//
// Optional feature macro: ARB_STALL_CNT_EN
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic                         fifo_push,
  output logic [BIT_WIDTH-1:0]         fifo_push_data,
  input  logic                         fifo_full,
  output logic [$clog2(N_REQ)-1:0]     owner,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]                  stall_cnt,
`endif
  output logic                         busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] owner_sel;
  logic             push_ok;
  logic [CNT_W-1:0] burst_next;
  int               scan;

  // Increment with explicit wrap so non-power-of-two N_REQ never lands on an
  // index that has no requester.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Rotating-priority scan: first requester at or after rr_ptr (mod N_REQ).
  // Falls back to rr_ptr itself when nobody is requesting.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan);
      end
    end
  end

  // Pushing is only ever legal with FIFO space and outside reset.
  assign push_ok    = !fifo_full && !rst;
  assign burst_next = burst_cnt_q + 1'b1;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    owner_sel   = rr_ptr_q;
    fifo_push   = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      IDLE: begin
        owner_sel = win_idx;
        // A blocked request takes no lock; arbitration simply reruns next cycle.
        if (win_found && push_ok) begin
          fifo_push = 1'b1;
          if (BURST_LEN == 1) begin
            rr_ptr_d = next_idx(win_idx);
          end else begin
            lock_id_d   = win_idx;
            burst_cnt_d = CNT_W'(1);
            state_d     = LOCK;
          end
        end
      end

      LOCK: begin
        owner_sel = lock_id_q;
        busy      = 1'b1;
        if (!req[lock_id_q]) begin
          // Owner ran dry before its burst ended: release and rotate.
          state_d  = IDLE;
          rr_ptr_d = next_idx(lock_id_q);
        end else if (push_ok) begin
          fifo_push   = 1'b1;
          burst_cnt_d = burst_next;
          if (burst_next == CNT_W'(BURST_LEN)) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(lock_id_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign owner          = owner_sel;
  assign gnt            = fifo_push ? (N_REQ'(1) << owner_sel) : '0;
  assign fifo_push_data = req_data[owner_sel*BIT_WIDTH +: BIT_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where some producer is waiting only because the FIFO is full.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req) && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Scoreboard bench for fifo_push_arbiter. A driver applies one cycle of
// stimulus at a time, evaluates a behavioural model of the arbitration rules
// and queues the expected per-cycle response. An independent monitor pops and
// compares on every falling edge. Producer i supplies words 0xA0+16*i+n,
// advancing n whenever its word is accepted.
// -----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int B  = 4;
  localparam int IW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic             fifo_push;
  logic [W-1:0]     fifo_push_data;
  logic             fifo_full;
  logic [IW-1:0]    owner;
  logic             busy;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  fifo_push_arbiter #(.N_REQ(N), .BIT_WIDTH(W), .BURST_LEN(B)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_push      (fifo_push),
    .fifo_push_data (fifo_push_data),
    .fifo_full      (fifo_full),
    .owner          (owner),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          push;
    logic [N-1:0]  gnt;
    logic [W-1:0]  data;
    logic [IW-1:0] owner;
    logic          busy;
    logic [15:0]   stall;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: who holds the port, words sent in this burst, next priority.
  bit   m_locked = 1'b0;
  int   m_lock   = 0;
  int   m_words  = 0;
  int   m_ptr    = 0;
  int   m_stall  = 0;
  int   word_n[N];
  bit   m_last_push;
  int   m_last_own;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, predict the DUT response and update the model.
  task automatic cycle(input logic [N-1:0] r, input logic full, input logic rs);
    exp_t e;
    int   own;
    bit   found;
    bit   push_e;
    int   idx;
    @(posedge clk);
    #1;
    req       = r;
    fifo_full = full;
    rst       = rs;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(160 + 16*i + word_n[i]);

    // Who is being served this cycle.
    if (m_locked) begin
      own = m_lock;
    end else begin
      own   = m_ptr;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && r[idx]) begin
          found = 1'b1;
          own   = idx;
        end
      end
    end
    push_e = !rs && !full && r[own];

    e.push  = push_e;
    e.gnt   = push_e ? N'(1 << own) : '0;
    e.data  = W'(160 + 16*own + word_n[own]);
    e.owner = IW'(own);
    e.busy  = m_locked;
    e.stall = 16'(m_stall);
    exp_q.push_back(e);

    m_last_push = push_e;
    m_last_own  = own;
    if (push_e) word_n[own]++;

    if (rs) begin
      m_locked = 1'b0;
      m_lock   = 0;
      m_words  = 0;
      m_ptr    = 0;
      m_stall  = 0;
    end else begin
      if ((|r) && full && m_stall < 65535) m_stall++;
      if (m_locked) begin
        if (!r[m_lock]) begin
          m_locked = 1'b0;
          m_ptr    = (m_lock + 1) % N;
        end else if (push_e) begin
          m_words++;
          if (m_words == B) begin
            m_locked = 1'b0;
            m_ptr    = (m_lock + 1) % N;
          end
        end
      end else if (push_e) begin
        if (B == 1) begin
          m_ptr = (own + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_lock   = own;
          m_words  = 1;
        end
      end
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fifo_push", 32'(fifo_push), 32'(e.push));
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("push_data", 32'(fifo_push_data), 32'(e.data));
        check("owner", 32'(owner), 32'(e.owner));
        check("busy", 32'(busy), 32'(e.busy));
`ifdef ARB_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) word_n[i] = 0;
    repeat (2) @(posedge clk);

    // Reset state, then idle with no requests.
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (5) cycle(4'b0000, 1'b0, 1'b0);

    // Two requesters alternate in bursts of B words.
    repeat (20) cycle(4'b0101, 1'b0, 1'b0);

    // Requester 1 locked with two words sent, then FIFO full for 3 cycles.
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (2) cycle(4'b0010, 1'b0, 1'b0);
    repeat (3) cycle(4'b0010, 1'b1, 1'b0);
    repeat (2) cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);   // owner shows rr_ptr = 2

    // Requester 3 drops after one word while requester 0 waits.
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    repeat (2) cycle(4'b0001, 1'b0, 1'b0);

    // Reset in the middle of a burst.
    repeat (2) cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b1);
    repeat (3) cycle(4'b1111, 1'b0, 1'b0);

    // Blocked request: stall counting (when present) and full-in-IDLE.
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (10) cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0);

    // Randomized traffic obeying the hold-until-granted rule.
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      cycle(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      for (int i = 0; i < N; i++) begin
        if (m_last_push && m_last_own == i) rq[i] = ($urandom_range(0, 3) != 0);
        else if (!rq[i])                    rq[i] = ($urandom_range(0, 2) == 0);
      end
    end

    repeat (3) @(negedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
